// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI responder (spi_slave) and its
// pin synchronizer (spi_sync).
//   spi_slave_state_t   : responder frame-tracking states
//   BITS_PER_BYTE       : SPI frame width
//   SPI_DEFAULT_TX_BYTE : byte shifted out when no response byte is loaded
// ----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_IDLE     = 2'd1,
        S_ACTIVE   = 2'd2
    } spi_slave_state_t;

    localparam int         BITS_PER_BYTE       = 8;
    localparam logic [7:0] SPI_DEFAULT_TX_BYTE = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// ----------------------------------------------------------------------------
// spi_sync
// Brings one asynchronous SPI pin into the i_clk domain: a STAGES-deep
// synchronizer followed by a delay flop, with registered edge strobes.
// The strobe appears STAGES + 1 cycles after the pin transition, and o_level
// is aligned with the strobes (it already shows the new value when a strobe
// is high).
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_pin          : asynchronous pin
//   o_level        : synchronized level (reset value RESET_VAL)
//   o_rise, o_fall : one-cycle edge strobes
// ----------------------------------------------------------------------------
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk) begin
                    if (!i_rst_n) q_reg <= RESET_VAL;
                    else          q_reg <= i_pin;
                end
            end else begin : g_rest
                always_ff @(posedge i_clk) begin
                    if (!i_rst_n) q_reg <= RESET_VAL;
                    else          q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    logic sync_out;
    logic dly_reg;
    logic rise_reg;
    logic fall_reg;

    assign sync_out = g_stage[STAGES-1].q_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dly_reg  <= RESET_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            dly_reg  <= sync_out;
            rise_reg <= sync_out & ~dly_reg;
            fall_reg <= ~sync_out & dly_reg;
        end
    end

    assign o_level = dly_reg;
    assign o_rise  = rise_reg;
    assign o_fall  = fall_reg;

endmodule

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames) that
// oversamples SCLK/MOSI/CS_n in the i_clk domain.
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_sclk, i_mosi, i_cs_n  : SPI pins from the master (asynchronous)
//   o_miso, o_miso_oe       : SPI data to the master and its output enable
//   i_tx_valid, i_tx_byte   : response byte offered to the holding register
//   o_tx_ready              : holding register empty
//   o_rx_valid, o_rx_byte   : one-cycle pulse with each complete received byte
//   o_tx_underrun           : pulse when a default byte goes out on the wire
// ----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter logic [7:0] DEFAULT_TX_BYTE = SPI_DEFAULT_TX_BYTE
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_cs_n,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_tx_underrun
);

    localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);
    // The synchronizer chain resets to "deasserted"; it takes this many cycles
    // for a genuinely low CS_n to appear at the level output after reset.
    localparam int DISARM_CYCLES = SYNC_STAGES + 1;
    localparam int DCNT_W        = $clog2(DISARM_CYCLES + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_sclk),
        .o_level(sclk_level_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_cs_n),
        .o_level(cs_level), .o_rise(cs_rise), .o_fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_mosi),
        .o_level(mosi_level), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
    );

    spi_slave_state_t             state_reg, state_next;
    logic [DCNT_W-1:0]            disarm_cnt_reg, disarm_cnt_next;
    logic [BIT_CNT_W-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [BITS_PER_BYTE-2:0]     rx_shift_reg, rx_shift_next;
    logic [7:0]                   rx_byte_reg, rx_byte_next;
    logic                         rx_valid_reg, rx_valid_next;
    logic [7:0]                   tx_shift_reg, tx_shift_next;
    logic                         miso_reg, miso_next;
    logic [7:0]                   hold_reg, hold_next;
    logic                         hold_full_reg, hold_full_next;
    logic                         under_pend_reg, under_pend_next;
    logic                         underrun_reg, underrun_next;
    logic                         load_point;
    logic [7:0]                   load_byte;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= S_DISARMED;
            disarm_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            rx_shift_reg   <= '0;
            rx_byte_reg    <= 8'h00;
            rx_valid_reg   <= 1'b0;
            tx_shift_reg   <= 8'h00;
            miso_reg       <= 1'b0;
            hold_reg       <= 8'h00;
            hold_full_reg  <= 1'b0;
            under_pend_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            disarm_cnt_reg <= disarm_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            rx_shift_reg   <= rx_shift_next;
            rx_byte_reg    <= rx_byte_next;
            rx_valid_reg   <= rx_valid_next;
            tx_shift_reg   <= tx_shift_next;
            miso_reg       <= miso_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            under_pend_reg <= under_pend_next;
            underrun_reg   <= underrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        disarm_cnt_next = disarm_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        rx_shift_next   = rx_shift_reg;
        rx_byte_next    = rx_byte_reg;
        rx_valid_next   = 1'b0;
        tx_shift_next   = tx_shift_reg;
        miso_next       = miso_reg;
        hold_next       = hold_reg;
        hold_full_next  = hold_full_reg;
        under_pend_next = under_pend_reg;
        underrun_next   = 1'b0;
        load_point      = 1'b0;
        load_byte       = DEFAULT_TX_BYTE;

        case (state_reg)
            S_DISARMED: begin
                // Only arm after CS_n has read high for longer than the
                // synchronizer's reset-value flush time.
                if (cs_level) begin
                    if (disarm_cnt_reg == DCNT_W'(DISARM_CYCLES)) state_next = S_IDLE;
                    else disarm_cnt_next = disarm_cnt_reg + DCNT_W'(1);
                end else begin
                    disarm_cnt_next = '0;
                end
            end
            S_IDLE: begin
                if (cs_fall) begin
                    state_next   = S_ACTIVE;
                    bit_cnt_next = '0;
                    load_point   = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    state_next      = S_IDLE;
                    bit_cnt_next    = '0;
                    miso_next       = 1'b0;
                    under_pend_next = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_next = {rx_shift_reg[BITS_PER_BYTE-3:0], mosi_level};
                        bit_cnt_next  = bit_cnt_reg + BIT_CNT_W'(1);
                        if (bit_cnt_reg == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                            rx_byte_next  = {rx_shift_reg, mosi_level};
                            rx_valid_next = 1'b1;
                        end
                        // Underrun is reported only once a default byte actually
                        // starts clocking out; the load point after the last byte
                        // of a frame never reaches the wire.
                        if (under_pend_reg) begin
                            underrun_next   = 1'b1;
                            under_pend_next = 1'b0;
                        end
                    end
                    if (sclk_fall) begin
                        // Counter back at 0 means this fall closes a full byte.
                        if (bit_cnt_reg == '0) begin
                            load_point = 1'b1;
                        end else begin
                            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                            miso_next     = tx_shift_reg[6];
                        end
                    end
                end
            end
            default: state_next = S_DISARMED;
        endcase

        if (load_point) begin
            if (hold_full_reg) begin
                load_byte      = hold_reg;
                hold_full_next = 1'b0;
            end else begin
                under_pend_next = 1'b1;
            end
            tx_shift_next = load_byte;
            miso_next     = load_byte[7];
        end

        // A write racing a load point lands after the load has already seen
        // the register empty, so the byte waits for the next load point.
        if (i_tx_valid && !hold_full_reg) begin
            hold_next      = i_tx_byte;
            hold_full_next = 1'b1;
        end
    end

    assign o_miso        = miso_reg;
    assign o_miso_oe     = (state_reg == S_ACTIVE);
    assign o_tx_ready    = ~hold_full_reg;
    assign o_rx_valid    = rx_valid_reg;
    assign o_rx_byte     = rx_byte_reg;
    assign o_tx_underrun = underrun_reg;

endmodule
